// File: rtl/psum_drain_acc_if.sv
// rtl/psum_drain_acc_if.sv - lane input and aligned row output bundle for psum_drain_acc
interface psum_drain_acc_if #(
  parameter int PE_SIZE    = 2,
  parameter int PSUM_WIDTH = 32
);
  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i;
  logic [PE_SIZE-1:0]            psum_en_row_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [PSUM_WIDTH*PE_SIZE-1:0] out_row_o;
  logic                          out_last_o;

  modport master (
    output psum_row_i, psum_en_row_i, out_ready_i,
    input  out_valid_o, out_row_o, out_last_o
  );

  modport slave (
    input  psum_row_i, psum_en_row_i, out_ready_i,
    output out_valid_o, out_row_o, out_last_o
  );
endinterface

// File: rtl/psum_drain_acc.sv
// rtl/psum_drain_acc.sv - per-lane K-tile psum accumulator with aligned row drain
// Optional macro PSUM_SAT_EN selects signed saturating accumulation instead of wrap-around.
module psum_drain_acc #(
  parameter int PE_SIZE    = 2,
  parameter int PSUM_WIDTH = 32,
  parameter int ACC_DEPTH  = 4,
  parameter int TILE_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [TILE_W-1:0] num_tiles_i,
  psum_drain_acc_if.slave   bus,
  output logic              busy_o,
  output logic              overflow_o
);
  localparam int AW = $clog2(ACC_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                        state, state_nxt;
  logic [TILE_W-1:0]             ntiles;
  logic [AW-1:0]                 wptr [PE_SIZE];
  logic [TILE_W-1:0]             tcnt [PE_SIZE];
  logic [PE_SIZE-1:0]            done;
  logic [PSUM_WIDTH-1:0]         acc  [PE_SIZE][ACC_DEPTH];
  logic [AW-1:0]                 rptr, rsel;
  logic [PSUM_WIDTH*PE_SIZE-1:0] row_rd;
  logic                          xfer;

  function automatic logic [PSUM_WIDTH-1:0] acc_add(input logic [PSUM_WIDTH-1:0] a,
                                                    input logic [PSUM_WIDTH-1:0] b);
    logic [PSUM_WIDTH-1:0] s;
    s = a + b;
`ifdef PSUM_SAT_EN
    // Signed overflow only when both operands share a sign the sum does not.
    if (a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1] && s[PSUM_WIDTH-1] != a[PSUM_WIDTH-1])
      s = a[PSUM_WIDTH-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
`endif
    return s;
  endfunction

  assign xfer   = bus.out_valid_o && bus.out_ready_i;
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = ACCUM;
      ACCUM:   if (&done) state_nxt = DRAIN;
      DRAIN:   if (xfer && bus.out_last_o) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row 0 is preloaded on entry to DRAIN; afterwards the next row is prefetched per transfer.
  always_comb begin
    rsel   = (state == DRAIN) ? rptr + AW'(1) : '0;
    row_rd = '0;
    for (int c = 0; c < PE_SIZE; c++)
      row_rd[PSUM_WIDTH*(PE_SIZE-c)-1 -: PSUM_WIDTH] = acc[c][rsel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ntiles          <= '0;
      done            <= '0;
      rptr            <= '0;
      overflow_o      <= 1'b0;
      bus.out_valid_o <= 1'b0;
      bus.out_last_o  <= 1'b0;
      bus.out_row_o   <= '0;
      for (int c = 0; c < PE_SIZE; c++) begin
        wptr[c] <= '0;
        tcnt[c] <= '0;
        for (int r = 0; r < ACC_DEPTH; r++) acc[c][r] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|bus.psum_en_row_i) overflow_o <= 1'b1;
          if (start_i) begin
            ntiles <= (num_tiles_i == '0) ? TILE_W'(1) : num_tiles_i;
            done   <= '0;
            for (int c = 0; c < PE_SIZE; c++) begin
              wptr[c] <= '0;
              tcnt[c] <= '0;
            end
          end
        end
        ACCUM: begin
          for (int c = 0; c < PE_SIZE; c++) begin
            if (bus.psum_en_row_i[PE_SIZE-1-c]) begin
              if (done[c]) begin
                overflow_o <= 1'b1;
              end else begin
                if (tcnt[c] == '0)
                  acc[c][wptr[c]] <= bus.psum_row_i[PSUM_WIDTH*(PE_SIZE-c)-1 -: PSUM_WIDTH];
                else
                  acc[c][wptr[c]] <= acc_add(acc[c][wptr[c]],
                                             bus.psum_row_i[PSUM_WIDTH*(PE_SIZE-c)-1 -: PSUM_WIDTH]);
                wptr[c] <= wptr[c] + AW'(1);
                if (wptr[c] == AW'(ACC_DEPTH-1)) begin
                  tcnt[c] <= tcnt[c] + TILE_W'(1);
                  if (tcnt[c] + TILE_W'(1) == ntiles) done[c] <= 1'b1;
                end
              end
            end
          end
          if (&done) begin
            bus.out_valid_o <= 1'b1;
            bus.out_row_o   <= row_rd;
            bus.out_last_o  <= 1'b0;
            rptr            <= '0;
          end
        end
        DRAIN: begin
          if (|bus.psum_en_row_i) overflow_o <= 1'b1;
          if (xfer) begin
            if (bus.out_last_o) begin
              bus.out_valid_o <= 1'b0;
              bus.out_last_o  <= 1'b0;
            end else begin
              rptr           <= rptr + AW'(1);
              bus.out_row_o  <= row_rd;
              bus.out_last_o <= (rptr + AW'(1) == AW'(ACC_DEPTH-1));
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_drain_acc.sv
// tb/tb_psum_drain_acc.sv - directed self-checking bench for psum_drain_acc
module tb_psum_drain_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_tiles = '0;
  logic       busy, overflow;

  psum_drain_acc_if #(.PE_SIZE(2), .PSUM_WIDTH(32)) bus ();

  psum_drain_acc #(.PE_SIZE(2), .PSUM_WIDTH(32), .ACC_DEPTH(4), .TILE_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .num_tiles_i(num_tiles),
    .bus(bus), .busy_o(busy), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] la [4];
  logic [31:0] lb [4];
  logic [31:0] ea [4];
  logic [31:0] eb [4];
  logic [63:0] got_row [8];
  logic        got_last [8];
  int          got_n;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // en[1] is lane 0, en[0] is lane 1
  task automatic set_lanes(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1);
    bus.psum_en_row_i = en;
    bus.psum_row_i    = {d0, d1};
  endtask

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    num_tiles = n;
    tick();
    start = 1'b0;
  endtask

  // lane 1 lags lane 0 by one cycle
  task automatic run_tile;
    for (int j = 0; j < 5; j++) begin
      set_lanes({j < 4, j >= 1}, (j < 4) ? la[j%4] : 32'h0, (j >= 1) ? lb[(j+3)%4] : 32'h0);
      tick();
    end
    set_lanes(2'b00, 32'h0, 32'h0);
  endtask

  task automatic collect_rows(input int upto);
    for (int k = 0; k < 60 && got_n < upto; k++) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        got_row[got_n]  = bus.out_row_o;
        got_last[got_n] = bus.out_last_o;
        got_n++;
      end
      tick();
    end
  endtask

  task automatic scenario1_vals;
    la = '{32'd1, 32'd2, 32'd3, 32'd4};
    lb = '{32'd10, 32'd20, 32'd30, 32'd40};
    ea = la;
    eb = lb;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    set_lanes(2'b00, 32'h0, 32'h0);
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.out_valid_o); end
    n_checks++; if (bus.out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", bus.out_last_o); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_checks++; if (bus.out_row_o !== 64'h0) begin n_fail++; $display("FAIL reset_row got %h exp 0", bus.out_row_o); end
  endtask

  task automatic test_single_tile;
    start_job(8'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_accum got %b exp 1", busy); end
    scenario1_vals();
    run_tile();
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL t1_valid_t+1 got %b exp 0", bus.out_valid_o); end
    tick();
    n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL t1_valid_t+2 got %b exp 1", bus.out_valid_o); end
    got_n = 0;
    collect_rows(4);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL t1_row_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_row[i] !== {ea[i], eb[i]}) begin n_fail++; $display("FAIL t1_row%0d got %h exp %h", i, got_row[i], {ea[i], eb[i]}); end
      n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL t1_last%0d got %b exp %b", i, got_last[i], i == 3); end
    end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL t1_valid_after got %b exp 0", bus.out_valid_o); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after got %b exp 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t1_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_two_tiles;
    start_job(8'd2);
    scenario1_vals();
    run_tile();
    la = '{32'd100, 32'd100, 32'd100, 32'd100};
    lb = la;
    run_tile();
    ea = '{32'd101, 32'd102, 32'd103, 32'd104};
    eb = '{32'd110, 32'd120, 32'd130, 32'd140};
    got_n = 0;
    collect_rows(4);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL t2_row_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_row[i] !== {ea[i], eb[i]}) begin n_fail++; $display("FAIL t2_row%0d got %h exp %h", i, got_row[i], {ea[i], eb[i]}); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    start_job(8'd1);
    scenario1_vals();
    run_tile();
    got_n = 0;
    collect_rows(1);
    bus.out_ready_i = 1'b0;
    start = 1'b1;
    num_tiles = 8'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL t3_hold_valid%0d got %b exp 1", k, bus.out_valid_o); end
      n_checks++; if (bus.out_row_o !== {32'd2, 32'd20}) begin n_fail++; $display("FAIL t3_hold_row%0d got %h exp %h", k, bus.out_row_o, {32'd2, 32'd20}); end
      n_checks++; if (bus.out_last_o !== 1'b0) begin n_fail++; $display("FAIL t3_hold_last%0d got %b exp 0", k, bus.out_last_o); end
    end
    start = 1'b0;
    bus.out_ready_i = 1'b1;
    collect_rows(4);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL t3_row_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_row[i] !== {ea[i], eb[i]}) begin n_fail++; $display("FAIL t3_row%0d got %h exp %h", i, got_row[i], {ea[i], eb[i]}); end
      n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL t3_last%0d got %b exp %b", i, got_last[i], i == 3); end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy_after got %b exp 0", busy); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL t3_valid_after got %b exp 0", bus.out_valid_o); end
  endtask

  task automatic test_wrap_sat;
    start_job(8'd2);
    la = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd6};
    lb = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_tile();
    la = '{32'd1, 32'd2, 32'd0, 32'd0};
    run_tile();
`ifdef PSUM_SAT_EN
    ea = '{32'h7FFF_FFFF, 32'h0000_0001, 32'd5, 32'd6};
`else
    ea = '{32'h8000_0000, 32'h0000_0001, 32'd5, 32'd6};
`endif
    eb = '{32'd0, 32'd0, 32'd0, 32'd0};
    got_n = 0;
    collect_rows(4);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL t4_row_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_row[i] !== {ea[i], eb[i]}) begin n_fail++; $display("FAIL t4_row%0d got %h exp %h", i, got_row[i], {ea[i], eb[i]}); end
    end
  endtask

  task automatic test_drop_in_drain;
    start_job(8'd1);
    scenario1_vals();
    run_tile();
    for (int k = 0; k < 10 && !bus.out_valid_o; k++) tick();
    n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL t5_drain_entry got %b exp 1", bus.out_valid_o); end
    bus.out_ready_i = 1'b0;
    set_lanes(2'b01, 32'h0, 32'h0000_DEAD);
    tick();
    set_lanes(2'b00, 32'h0, 32'h0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t5_overflow_set got %b exp 1", overflow); end
    bus.out_ready_i = 1'b1;
    got_n = 0;
    collect_rows(4);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL t5_row_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_row[i] !== {ea[i], eb[i]}) begin n_fail++; $display("FAIL t5_row%0d got %h exp %h", i, got_row[i], {ea[i], eb[i]}); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t5_overflow_sticky got %b exp 1", overflow); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t5_overflow_clear got %b exp 0", overflow); end
  endtask

  task automatic test_reset_mid_accum;
    start_job(8'd1);
    set_lanes(2'b10, 32'd7, 32'd0);
    tick();
    set_lanes(2'b11, 32'd8, 32'd70);
    tick();
    set_lanes(2'b00, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy_reset got %b exp 0", busy); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL t6_valid_reset got %b exp 0", bus.out_valid_o); end
    start_job(8'd1);
    scenario1_vals();
    run_tile();
    got_n = 0;
    collect_rows(4);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL t6_row_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_row[i] !== {ea[i], eb[i]}) begin n_fail++; $display("FAIL t6_row%0d got %h exp %h", i, got_row[i], {ea[i], eb[i]}); end
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t6_overflow got %b exp 0", overflow); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tile();
    test_two_tiles();
    test_backpressure();
    test_wrap_sat();
    test_drop_in_drain();
    test_reset_mid_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
